// File: rtl/rr_stage_hazard_ctrl.sv
// rr_stage_hazard_ctrl
//   Sequencing controller for the RR->EX boundary of the 6-stage pipeline.
//   It drives the enables of the PC, IF/ID, ID/RR and RR/EX registers and
//   the front-end flush. It also handles three pipeline events:
//     - load-use hazards against EX, which insert LU_BUBBLES bubbles;
//     - LM/SM instructions, which are split into one micro-op per selected
//       register in ascending address order;
//     - branch redirects from EX, which flush the front end.
//   Optional build macro HAZ_PERF_CNT_EN adds the saturating stall_cnt and
//   flush_cnt performance counters.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rr_*                     RR-stage instruction info (valid, operand use/addr, LM/SM mask)
//   ex_*                     EX-stage info (load, RF write, destination, redirect)
//   pc_en..rr_ex_en          pipeline register enables
//   rr_ex_bubble             RR/EX loads a NOP this cycle
//   flush_front              clear IF/ID and ID/RR this cycle
//   lmsm_active/addr/last    current LM/SM micro-op descriptor
//   stall_cnt, flush_cnt     (HAZ_PERF_CNT_EN only) saturating event counters
module rr_stage_hazard_ctrl #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned LU_BUBBLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rr_valid,
  input  logic                rr_uses_a,
  input  logic                rr_uses_b,
  input  logic [ADDR_W-1:0]   rr_src_a,
  input  logic [ADDR_W-1:0]   rr_src_b,
  input  logic                rr_is_lmsm,
  input  logic [NUM_REGS-1:0] rr_lmsm_mask,
  input  logic                ex_is_load,
  input  logic                ex_wr_en,
  input  logic [ADDR_W-1:0]   ex_dest,
  input  logic                ex_redirect,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                id_rr_en,
  output logic                rr_ex_en,
  output logic                rr_ex_bubble,
  output logic                flush_front,
  output logic                lmsm_active,
  output logic [ADDR_W-1:0]   lmsm_addr,
  output logic                lmsm_last
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, LMSM_SEQ} state_e;

  localparam logic [NUM_REGS-1:0] MASK_ONE    = NUM_REGS'(1);
  localparam logic [1:0]          LU_CNT_INIT = 2'(LU_BUBBLES - 1);

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] rem_q, rem_d;
  logic [1:0]          cnt_q, cnt_d;

  logic                lu_hazard;
  logic                lmsm_req;
  logic                lmsm_nop;
  logic [NUM_REGS-1:0] in_rest, rem_rest;
  logic                in_single, rem_single;

  function automatic logic [ADDR_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] m);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_REGS; i > 0; i--) begin
      if (m[i-1]) idx = ADDR_W'(i - 1);
    end
    return idx;
  endfunction

  assign lu_hazard = rr_valid & ex_is_load & ex_wr_en &
                     ((rr_uses_a & (rr_src_a == ex_dest)) |
                      (rr_uses_b & (rr_src_b == ex_dest)));
  assign lmsm_req  = rr_valid & rr_is_lmsm & (rr_lmsm_mask != '0);
  assign lmsm_nop  = rr_valid & rr_is_lmsm & (rr_lmsm_mask == '0);

  // m & (m-1) drops the lowest set bit; a zero result means it was the only one.
  assign in_rest    = rr_lmsm_mask & (rr_lmsm_mask - MASK_ONE);
  assign in_single  = (in_rest == '0);
  assign rem_rest   = rem_q & (rem_q - MASK_ONE);
  assign rem_single = (rem_rest == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (ex_redirect) begin
      state_d = RUN;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu_hazard) begin
            if (LU_BUBBLES > 1) begin
              state_d = LU_STALL;
              cnt_d   = LU_CNT_INIT;
            end
          end else if (lmsm_req && !in_single) begin
            // The first micro-op is issued straight from the input mask.
            rem_d   = in_rest;
            state_d = LMSM_SEQ;
          end
        end
        LU_STALL: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = RUN;
        end
        LMSM_SEQ: begin
          rem_d = rem_rest;
          if (rem_single) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          rem_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_rr_en     = 1'b1;
    rr_ex_en     = 1'b1;
    rr_ex_bubble = 1'b0;
    flush_front  = 1'b0;
    lmsm_active  = 1'b0;
    lmsm_addr    = '0;
    lmsm_last    = 1'b0;
    if (ex_redirect) begin
      flush_front  = 1'b1;
      rr_ex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu_hazard) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_rr_en     = 1'b0;
            rr_ex_bubble = 1'b1;
          end else if (lmsm_req) begin
            lmsm_active = 1'b1;
            lmsm_addr   = lowest_idx(rr_lmsm_mask);
            lmsm_last   = in_single;
            pc_en       = in_single;
            if_id_en    = in_single;
            id_rr_en    = in_single;
          end else if (lmsm_nop) begin
            rr_ex_bubble = 1'b1;
          end
        end
        LU_STALL: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_rr_en     = 1'b0;
          rr_ex_bubble = 1'b1;
        end
        LMSM_SEQ: begin
          lmsm_active = 1'b1;
          lmsm_addr   = lowest_idx(rem_q);
          lmsm_last   = rem_single;
          pc_en       = rem_single;
          if_id_en    = rem_single;
          id_rr_en    = rem_single;
        end
        default: begin
          rr_ex_bubble = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_front && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rr_stage_hazard_ctrl.sv
// Testbench for rr_stage_hazard_ctrl. Two instances share the stimulus:
// index 0 uses LU_BUBBLES=1 and index 1 uses LU_BUBBLES=3. A queue-style
// model predicts every output on every cycle. Literal expectations pin the
// key scenarios.
module tb_rr_stage_hazard_ctrl;

  localparam int NREG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rr_valid, rr_uses_a, rr_uses_b, rr_is_lmsm;
  logic [2:0] rr_src_a, rr_src_b, ex_dest;
  logic [7:0] rr_lmsm_mask;
  logic       ex_is_load, ex_wr_en, ex_redirect;

  logic [1:0] o_pc, o_ifid, o_idrr, o_rrex, o_bub, o_fl, o_act, o_last;
  logic [2:0] o_addr [2];
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] o_sc [2];
  logic [15:0] o_fc [2];
`endif

  rr_stage_hazard_ctrl #(.NUM_REGS(8), .ADDR_W(3), .LU_BUBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_uses_a(rr_uses_a), .rr_uses_b(rr_uses_b),
    .rr_src_a(rr_src_a), .rr_src_b(rr_src_b), .rr_is_lmsm(rr_is_lmsm), .rr_lmsm_mask(rr_lmsm_mask),
    .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en), .ex_dest(ex_dest), .ex_redirect(ex_redirect),
    .pc_en(o_pc[0]), .if_id_en(o_ifid[0]), .id_rr_en(o_idrr[0]), .rr_ex_en(o_rrex[0]),
    .rr_ex_bubble(o_bub[0]), .flush_front(o_fl[0]), .lmsm_active(o_act[0]),
    .lmsm_addr(o_addr[0]), .lmsm_last(o_last[0])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(o_sc[0]), .flush_cnt(o_fc[0])
`endif
  );

  rr_stage_hazard_ctrl #(.NUM_REGS(8), .ADDR_W(3), .LU_BUBBLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .rr_valid(rr_valid), .rr_uses_a(rr_uses_a), .rr_uses_b(rr_uses_b),
    .rr_src_a(rr_src_a), .rr_src_b(rr_src_b), .rr_is_lmsm(rr_is_lmsm), .rr_lmsm_mask(rr_lmsm_mask),
    .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en), .ex_dest(ex_dest), .ex_redirect(ex_redirect),
    .pc_en(o_pc[1]), .if_id_en(o_ifid[1]), .id_rr_en(o_idrr[1]), .rr_ex_en(o_rrex[1]),
    .rr_ex_bubble(o_bub[1]), .flush_front(o_fl[1]), .lmsm_active(o_act[1]),
    .lmsm_addr(o_addr[1]), .lmsm_last(o_last[1])
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(o_sc[1]), .flush_cnt(o_fc[1])
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Model state per instance: bubbles still owed, and a list of micro-op
  // addresses still to issue (head index + count).
  int m_pend [2];
  int m_ql   [2][NREG];
  int m_qh   [2];
  int m_qn   [2];
  int m_sc   [2];
  int m_fc   [2];

  int e_pc, e_ifid, e_idrr, e_rrex, e_bub, e_fl, e_act, e_addr, e_last;
  int lub;
  bit hz;

  // Hand-computed literal expectations for one instance in the current cycle
  bit lit_on = 1'b0;
  int lit_k, lit_pc, lit_bub, lit_fl, lit_act, lit_addr, lit_last;
  bit lit_cnt_on = 1'b0;
  int lit_sc, lit_fc;

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0d want %0d", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      lub = (k == 0) ? 1 : 3;
      e_pc = 1; e_ifid = 1; e_idrr = 1; e_rrex = 1;
      e_bub = 0; e_fl = 0; e_act = 0; e_addr = 0; e_last = 0;
      hz = rr_valid && ex_is_load && ex_wr_en &&
           ((rr_uses_a && rr_src_a == ex_dest) || (rr_uses_b && rr_src_b == ex_dest));
      if (ex_redirect) begin
        e_fl = 1; e_bub = 1;
        m_pend[k] = 0; m_qn[k] = 0;
      end else if (m_pend[k] > 0) begin
        e_pc = 0; e_ifid = 0; e_idrr = 0; e_bub = 1;
        m_pend[k]--;
      end else if (m_qn[k] == 0 && hz) begin
        e_pc = 0; e_ifid = 0; e_idrr = 0; e_bub = 1;
        m_pend[k] = lub - 1;
      end else begin
        if (m_qn[k] == 0 && rr_valid && rr_is_lmsm) begin
          if (rr_lmsm_mask == 8'h00) e_bub = 1;
          else begin
            m_qh[k] = 0;
            for (int i = 0; i < NREG; i++)
              if (rr_lmsm_mask[i]) begin
                m_ql[k][m_qn[k]] = i;
                m_qn[k]++;
              end
          end
        end
        if (m_qn[k] > 0) begin
          e_act  = 1;
          e_addr = m_ql[k][m_qh[k]];
          m_qh[k]++;
          m_qn[k]--;
          e_last = (m_qn[k] == 0) ? 1 : 0;
          e_pc = e_last; e_ifid = e_last; e_idrr = e_last;
        end
      end

      chk("pc_en",        k, int'(o_pc[k]),   e_pc);
      chk("if_id_en",     k, int'(o_ifid[k]), e_ifid);
      chk("id_rr_en",     k, int'(o_idrr[k]), e_idrr);
      chk("rr_ex_en",     k, int'(o_rrex[k]), e_rrex);
      chk("rr_ex_bubble", k, int'(o_bub[k]),  e_bub);
      chk("flush_front",  k, int'(o_fl[k]),   e_fl);
      chk("lmsm_active",  k, int'(o_act[k]),  e_act);
      chk("lmsm_addr",    k, int'(o_addr[k]), e_addr);
      chk("lmsm_last",    k, int'(o_last[k]), e_last);

      if (lit_on && lit_k == k) begin
        chk("lit_pc_en",       k, int'(o_pc[k]),   lit_pc);
        chk("lit_rr_ex_bubble",k, int'(o_bub[k]),  lit_bub);
        chk("lit_flush_front", k, int'(o_fl[k]),   lit_fl);
        chk("lit_lmsm_active", k, int'(o_act[k]),  lit_act);
        chk("lit_lmsm_addr",   k, int'(o_addr[k]), lit_addr);
        chk("lit_lmsm_last",   k, int'(o_last[k]), lit_last);
      end

`ifdef HAZ_PERF_CNT_EN
      chk("stall_cnt", k, int'(o_sc[k]), m_sc[k]);
      chk("flush_cnt", k, int'(o_fc[k]), m_fc[k]);
      if (lit_cnt_on && k == 0) begin
        chk("lit_stall_cnt", k, int'(o_sc[k]), lit_sc);
        chk("lit_flush_cnt", k, int'(o_fc[k]), lit_fc);
      end
      if (e_pc == 0 && m_sc[k] < 65535) m_sc[k]++;
      if (e_fl == 1 && m_fc[k] < 65535) m_fc[k]++;
      if (rst) begin m_sc[k] = 0; m_fc[k] = 0; end
`endif

      if (rst) begin
        m_pend[k] = 0; m_qn[k] = 0; m_qh[k] = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic ua, input logic ub, input logic [2:0] sa,
                       input logic [2:0] sb, input logic lm, input logic [7:0] mask,
                       input logic ld, input logic wr, input logic [2:0] dest, input logic rd);
    rr_valid = v; rr_uses_a = ua; rr_uses_b = ub; rr_src_a = sa; rr_src_b = sb;
    rr_is_lmsm = lm; rr_lmsm_mask = mask; ex_is_load = ld; ex_wr_en = wr;
    ex_dest = dest; ex_redirect = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 3'd0, 0);
  endtask

  task automatic lit(input int k, input int pc, input int bub, input int fl,
                     input int act, input int addr, input int last);
    lit_on = 1'b1; lit_k = k; lit_pc = pc; lit_bub = bub; lit_fl = fl;
    lit_act = act; lit_addr = addr; lit_last = last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lit_on = 1'b0;
    lit_cnt_on = 1'b0;
  endtask

  int a5 [4] = '{0, 2, 5, 7};

  initial begin
    rst = 1'b1;
    idle();
    tick();
    // reset state, both instances
    lit(0, 1, 0, 0, 0, 0, 0); tick();
    lit(1, 1, 0, 0, 0, 0, 0); tick();
    rst = 1'b0;

    // load-use on operand A, one bubble
    drive(1, 1, 0, 3'd3, 3'd0, 0, 8'h00, 1, 1, 3'd3, 0); lit(0, 0, 1, 0, 0, 0, 0); tick();
    idle(); lit(0, 1, 0, 0, 0, 0, 0); tick();
    idle(); tick(); idle(); tick();

    // no hazard: operand unused, or different destination
    drive(1, 0, 0, 3'd3, 3'd0, 0, 8'h00, 1, 1, 3'd3, 0); lit(0, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 3'd3, 3'd0, 0, 8'h00, 1, 1, 3'd4, 0); lit(0, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 1, 3'd0, 3'd3, 0, 8'h00, 0, 1, 3'd3, 0); tick();
    drive(1, 0, 1, 3'd0, 3'd3, 0, 8'h00, 1, 0, 3'd3, 0); tick();
    drive(0, 1, 1, 3'd3, 3'd3, 0, 8'h00, 1, 1, 3'd3, 0); lit(0, 1, 0, 0, 0, 0, 0); tick();
    // hazard on operand B
    drive(1, 0, 1, 3'd0, 3'd3, 0, 8'h00, 1, 1, 3'd3, 0); lit(1, 0, 1, 0, 0, 0, 0); tick();
    idle(); lit(1, 0, 1, 0, 0, 0, 0); tick();
    idle(); lit(1, 0, 1, 0, 0, 0, 0); tick();
    idle(); lit(1, 1, 0, 0, 0, 0, 0); tick();

    // LM mask 1010_0101 -> 0,2,5,7
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 3'd0, 3'd0, 1, 8'hA5, 0, 0, 3'd0, 0);
      lit(0, (i == 3) ? 1 : 0, 0, 0, 1, a5[i], (i == 3) ? 1 : 0);
      tick();
    end
    idle(); lit(0, 1, 0, 0, 0, 0, 0); tick();

    // single-bit mask and empty mask
    drive(1, 0, 0, 3'd0, 3'd0, 1, 8'h40, 0, 0, 3'd0, 0); lit(0, 1, 0, 0, 1, 6, 1); tick();
    drive(1, 0, 0, 3'd0, 3'd0, 1, 8'h00, 0, 0, 3'd0, 0); lit(0, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 3'd0, 3'd0, 1, 8'h80, 0, 0, 3'd0, 0); lit(1, 1, 0, 0, 1, 7, 1); tick();
    idle(); tick();

    // redirect during 2nd micro-op of mask FF
    drive(1, 0, 0, 3'd0, 3'd0, 1, 8'hFF, 0, 0, 3'd0, 0); lit(0, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 3'd0, 3'd0, 1, 8'hFF, 0, 0, 3'd0, 1); lit(0, 1, 1, 1, 0, 0, 0); tick();
    idle(); lit(0, 1, 0, 0, 0, 0, 0); tick();

    // reset mid LU_STALL (LU_BUBBLES=3)
    drive(1, 1, 0, 3'd5, 3'd0, 0, 8'h00, 1, 1, 3'd5, 0); lit(1, 0, 1, 0, 0, 0, 0); tick();
    idle(); rst = 1'b1; lit(1, 0, 1, 0, 0, 0, 0); tick();
    rst = 1'b0; idle(); lit(1, 1, 0, 0, 0, 0, 0); tick();

    // redirect mid LU_STALL
    drive(1, 1, 0, 3'd2, 3'd0, 0, 8'h00, 1, 1, 3'd2, 0); tick();
    idle(); ex_redirect = 1'b1; lit(1, 1, 1, 1, 0, 0, 0); tick();
    idle(); lit(1, 1, 0, 0, 0, 0, 0); tick();

    // reset mid LMSM_SEQ
    drive(1, 0, 0, 3'd0, 3'd0, 1, 8'hFF, 0, 0, 3'd0, 0); tick();
    drive(1, 0, 0, 3'd0, 3'd0, 1, 8'hFF, 0, 0, 3'd0, 0); lit(0, 0, 0, 0, 1, 1, 0); tick();
    rst = 1'b1; tick();
    rst = 1'b0; idle(); lit(0, 1, 0, 0, 0, 0, 0); tick();

    // load-use wins over LM/SM entry
    drive(1, 1, 0, 3'd2, 3'd0, 1, 8'h0F, 1, 1, 3'd2, 0); lit(0, 0, 1, 0, 0, 0, 0); tick();
    idle(); tick(); idle(); tick(); idle(); tick();

    // mixed directed sweep
    for (int i = 0; i < 32; i++) begin
      drive((i % 4) != 3, (i % 2) == 0, (i % 3) == 0, 3'(i % 8), 3'((i * 5) % 8),
            (i % 5) == 1, 8'((i * 37) % 256), (i % 3) != 1, (i % 4) != 2,
            3'((i * 3) % 8), (i % 11) == 7);
      tick();
    end
    idle(); tick(); idle(); tick(); idle(); tick();

`ifdef HAZ_PERF_CNT_EN
    rst = 1'b1; idle(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 3'd0, 3'd0, 1, 8'hA5, 0, 0, 3'd0, 0); tick();
    end
    idle(); ex_redirect = 1'b1; tick();
    idle(); lit_cnt_on = 1'b1; lit_sc = 3; lit_fc = 1; tick();
    u_dut1.stall_cnt_q = 16'hFFFF;
    m_sc[0] = 65535;
    drive(1, 1, 0, 3'd1, 3'd0, 0, 8'h00, 1, 1, 3'd1, 0); tick();
    idle(); lit_cnt_on = 1'b1; lit_sc = 65535; lit_fc = 1; tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
